// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding and default width for the alu_4_bit slice
package alu_pkg;

  localparam int ALU_DATA_W = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NOTA = 2'b10,
    OP_ORB  = 2'b11
  } opcode_e;

endpackage

// File: rtl/alu_4_bit_core.sv
// rtl/alu_4_bit_core.sv - combinational next result for alu_4_bit
// Z/N next-state outputs exist only when ALU_FLAGS_EN is defined.
module alu_4_bit_core
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [1:0]        Opcode,
`ifdef ALU_FLAGS_EN
  output logic              z_next,
  output logic              n_next,
`endif
  output logic [DATA_W:0]   c_next
);

  logic [DATA_W:0] a_ext;
  logic [DATA_W:0] b_ext;

  // One extra bit of headroom means add/sub can never wrap.
  assign a_ext = {A[DATA_W-1], A};
  assign b_ext = {B[DATA_W-1], B};

  always_comb begin
    c_next = a_ext + b_ext;
    case (Opcode)
      OP_ADD:  c_next = a_ext + b_ext;
      OP_SUB:  c_next = a_ext - b_ext;
      OP_NOTA: c_next = ~a_ext;
      OP_ORB:  c_next = {{DATA_W{1'b0}}, |B};
      default: c_next = a_ext + b_ext;
    endcase
  end

`ifdef ALU_FLAGS_EN
  assign z_next = (c_next == '0);
  assign n_next = c_next[DATA_W];
`endif

endmodule

// File: rtl/alu_4_bit.sv
// rtl/alu_4_bit.sv - registered signed ALU top; result register and async reset
// Optional registered Z/N flags are enabled by defining ALU_FLAGS_EN.
module alu_4_bit
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [1:0]        Opcode,
`ifdef ALU_FLAGS_EN
  output logic              Z,
  output logic              N,
`endif
  output logic [DATA_W:0]   C
);

  logic [DATA_W:0] c_next;
`ifdef ALU_FLAGS_EN
  logic z_next;
  logic n_next;
`endif

  alu_4_bit_core #(.DATA_W(DATA_W)) u_core (
    .A      (A),
    .B      (B),
    .Opcode (Opcode),
`ifdef ALU_FLAGS_EN
    .z_next (z_next),
    .n_next (n_next),
`endif
    .c_next (c_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      C <= '0;
    end else begin
      C <= c_next;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Z <= 1'b0;
      N <= 1'b0;
    end else begin
      Z <= z_next;
      N <= n_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu_4_bit.sv
// tb/tb_alu_4_bit.sv - self-checking bench for alu_4_bit (Z/N checked when ALU_FLAGS_EN is defined)
module tb_alu_4_bit;
  import alu_pkg::*;

  localparam int W = ALU_DATA_W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [1:0]   Opcode = 2'b00;
  logic [W:0]   C;
`ifdef ALU_FLAGS_EN
  logic         Z;
  logic         N;
`endif

  always #5 clk = ~clk;

  alu_4_bit #(.DATA_W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .Opcode (Opcode),
`ifdef ALU_FLAGS_EN
    .Z      (Z),
    .N      (N),
`endif
    .C      (C)
  );

  typedef struct {
    int         a;
    int         b;
    logic [1:0] op;
    int         c;
    bit         z;
    bit         n;
  } vec_t;

  typedef struct {
    int idx;
    int c;
    bit z;
    bit n;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string name, input int c, input bit z, input bit n);
    check({name, " C"}, int'($signed(C)), c);
`ifdef ALU_FLAGS_EN
    check({name, " Z"}, int'(Z), int'(z));
    check({name, " N"}, int'(N), int'(n));
`endif
  endtask

  function automatic void add_vec(input int a, input int b, input logic [1:0] op, input int c,
                                  input bit z, input bit n);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.c = c; v.z = z; v.n = n;
    vecs.push_back(v);
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      check_all($sformatf("vec%0d", e.idx), e.c, e.z, e.n);
    end
  endtask

  // Back-to-back stream: each negedge checks the previous vector, then drives the next.
  task automatic run_vectors();
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (sb.size() > 0) compare_head();
      A      = W'(vecs[i].a);
      B      = W'(vecs[i].b);
      Opcode = vecs[i].op;
      e.idx = i; e.c = vecs[i].c; e.z = vecs[i].z; e.n = vecs[i].n;
      sb.push_back(e);
    end
    @(negedge clk);
    compare_head();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // ADD sweep over {7,0,-8}
    add_vec( 7,  7, OP_ADD,  14, 0, 0);
    add_vec( 7,  0, OP_ADD,   7, 0, 0);
    add_vec( 7, -8, OP_ADD,  -1, 0, 1);
    add_vec( 0,  7, OP_ADD,   7, 0, 0);
    add_vec( 0,  0, OP_ADD,   0, 1, 0);
    add_vec( 0, -8, OP_ADD,  -8, 0, 1);
    add_vec(-8,  7, OP_ADD,  -1, 0, 1);
    add_vec(-8,  0, OP_ADD,  -8, 0, 1);
    add_vec(-8, -8, OP_ADD, -16, 0, 1);
    // SUB sweep over {7,0,-8}
    add_vec( 7,  7, OP_SUB,   0, 1, 0);
    add_vec( 7,  0, OP_SUB,   7, 0, 0);
    add_vec( 7, -8, OP_SUB,  15, 0, 0);
    add_vec( 0,  7, OP_SUB,  -7, 0, 1);
    add_vec( 0,  0, OP_SUB,   0, 1, 0);
    add_vec( 0, -8, OP_SUB,   8, 0, 0);
    add_vec(-8,  7, OP_SUB, -15, 0, 1);
    add_vec(-8,  0, OP_SUB,  -8, 0, 1);
    add_vec(-8, -8, OP_SUB,   0, 1, 0);
    // NOT A, B arbitrary
    add_vec( 7,  3, OP_NOTA, -8, 0, 1);
    add_vec( 0, -1, OP_NOTA, -1, 0, 1);
    add_vec(-8,  5, OP_NOTA,  7, 0, 0);
    add_vec(-1,  0, OP_NOTA,  0, 1, 0);
    // Reduction OR of B, A arbitrary
    add_vec( 5,  7, OP_ORB,   1, 0, 0);
    add_vec(-1,  0, OP_ORB,   0, 1, 0);
    add_vec( 0, -8, OP_ORB,   1, 0, 0);
    add_vec( 7, -1, OP_ORB,   1, 0, 0);
    // Flag corner cases
    add_vec( 7, -7, OP_ADD,   0, 1, 0);
    add_vec(-8,  7, OP_SUB, -15, 0, 1);

    // Reset is asynchronous: C clears before any clock edge
    A = 4'd1; B = 4'd1; Opcode = OP_ADD;
    #1 reset = 1'b1;
    #1 check_all("reset async", 0, 0, 0);
    @(negedge clk);
    check_all("reset held over edge", 0, 0, 0);
    reset = 1'b0;
    #3 check_all("released before edge", 0, 0, 0);
    @(negedge clk);
    check_all("first edge after reset", 2, 0, 0);

    run_vectors();

    // Mid-stream reset clears a negative result without waiting for a clock
    A = 4'h8; B = 4'h8; Opcode = OP_ADD;
    @(negedge clk);
    check_all("pre-reset -8+-8", -16, 0, 1);
    #2 reset = 1'b1;
    #1 check_all("mid-stream reset", 0, 0, 0);
    A = 4'd7; B = 4'd7;
    @(negedge clk);
    check_all("reset holds", 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    check_all("resume 7+7", 14, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
